// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the eight-digit seven-segment scan driver.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 8;
  localparam int DIGIT_W    = $clog2(NUM_DIGITS);

  // Segment bit positions inside one digit byte, {a,b,c,d,e,f,g,dp}
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  typedef logic [NUM_DIGITS-1:0][SEG_W-1:0] frame_t;

  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_SHOW  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running modulo-N counter with a terminal-count pulse on the last count.
module tick_gen #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_tc  = i_en && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Double-buffered, time-multiplexed driver for two 4-digit seven-segment banks.
// Optional per-digit blinking is compiled in with `define SEG_SCAN_BLINK_EN.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLANK_CYC = 4
`ifdef SEG_SCAN_BLINK_EN
  , parameter int BLINK_DIV = 50_000_000
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_valid,
  output logic                        frame_ready,
  input  logic [NUM_DIGITS*SEG_W-1:0] frame_seg,
  input  logic [NUM_DIGITS-1:0]       frame_en,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]       blink_mask,
`endif
  output logic [SEG_W-1:0]            seg_left,
  output logic [SEG_W-1:0]            seg_right,
  output logic [NUM_DIGITS-1:0]       an
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] BLANK_L = CW'(BLANK_CYC);

  logic [CW-1:0]         w_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic                  w_tc;
  logic [DIGIT_W-1:0]    r_digit;
  logic [DIGIT_W-1:0]    w_digit_nxt;
  slot_state_t           r_state;
  slot_state_t           w_state_nxt;
  logic                  w_swap;
  logic                  w_accept;
  logic                  r_pending;
  frame_t                r_sh_seg;
  frame_t                r_disp_seg;
  frame_t                w_disp_seg_nxt;
  logic [NUM_DIGITS-1:0] r_sh_en;
  logic [NUM_DIGITS-1:0] r_disp_en;
  logic [NUM_DIGITS-1:0] w_disp_en_nxt;
  logic                  w_blink_off;
  logic [SEG_W-1:0]      w_seg_cur;

  tick_gen #(.N(SCAN_DIV), .W(CW)) u_slot (
    .clk   (clk),
    .rst   (rst),
    .i_en  (1'b1),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  assign w_cnt_nxt   = w_tc ? '0 : w_cnt + 1'b1;
  assign w_swap      = w_tc && (r_digit == DIGIT_W'(NUM_DIGITS - 1)) && r_pending;
  assign w_accept    = frame_valid && !r_pending;
  assign frame_ready = !r_pending;

  always_comb begin
    w_state_nxt = r_state;
    w_digit_nxt = r_digit;
    if (w_tc) w_digit_nxt = r_digit + 1'b1;
    case (r_state)
      SLOT_BLANK: if (w_cnt_nxt >= BLANK_L) w_state_nxt = SLOT_SHOW;
      SLOT_SHOW:  if (w_cnt_nxt <  BLANK_L) w_state_nxt = SLOT_BLANK;
      default:    w_state_nxt = SLOT_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit <= '0;
      r_state <= (BLANK_CYC > 0) ? SLOT_BLANK : SLOT_SHOW;
    end else begin
      r_digit <= w_digit_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Shadow/display double buffer; display only changes at the 7->0 wrap
  assign w_disp_seg_nxt = w_swap ? r_sh_seg : r_disp_seg;
  assign w_disp_en_nxt  = w_swap ? r_sh_en  : r_disp_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= 1'b0;
      r_sh_seg   <= '0;
      r_sh_en    <= '0;
      r_disp_seg <= '0;
      r_disp_en  <= '0;
    end else begin
      if (w_swap) begin
        r_disp_seg <= r_sh_seg;
        r_disp_en  <= r_sh_en;
        r_pending  <= 1'b0;
      end
      if (w_accept) begin
        r_sh_seg  <= frame_seg;
        r_sh_en   <= frame_en;
        r_pending <= 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0]         w_blink_cnt_unused;
  logic                  w_blink_tc;
  logic                  r_phase;
  logic                  w_phase_nxt;
  logic [NUM_DIGITS-1:0] r_sh_mask;
  logic [NUM_DIGITS-1:0] r_disp_mask;
  logic [NUM_DIGITS-1:0] w_disp_mask_nxt;

  tick_gen #(.N(BLINK_DIV), .W(BW)) u_blink (
    .clk   (clk),
    .rst   (rst),
    .i_en  (1'b1),
    .o_cnt (w_blink_cnt_unused),
    .o_tc  (w_blink_tc)
  );

  assign w_phase_nxt     = r_phase ^ w_blink_tc;
  assign w_disp_mask_nxt = w_swap ? r_sh_mask : r_disp_mask;
  assign w_blink_off     = w_phase_nxt && w_disp_mask_nxt[w_digit_nxt];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase     <= 1'b0;
      r_sh_mask   <= '0;
      r_disp_mask <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      if (w_swap)   r_disp_mask <= r_sh_mask;
      if (w_accept) r_sh_mask   <= blink_mask;
    end
  end
`else
  assign w_blink_off = 1'b0;
`endif

  // Registered outputs follow the post-update digit/state
  assign w_seg_cur = (w_disp_en_nxt[w_digit_nxt] && !w_blink_off) ?
                     w_disp_seg_nxt[w_digit_nxt] : SEG_BLANK;

  always_ff @(posedge clk) begin
    if (rst) begin
      an        <= '0;
      seg_left  <= SEG_BLANK;
      seg_right <= SEG_BLANK;
    end else begin
      an        <= (w_state_nxt == SLOT_SHOW) ? (NUM_DIGITS'(1) << w_digit_nxt) : '0;
      seg_left  <= w_digit_nxt[DIGIT_W-1] ? w_seg_cur : SEG_BLANK;
      seg_right <= w_digit_nxt[DIGIT_W-1] ? SEG_BLANK : w_seg_cur;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver against a cycle-index reference model.
module tb_seg_scan_driver;

  localparam int SD = 4;
  localparam int BC = 1;
  localparam int BD = 16;
  localparam int FP = 8 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_valid;
  logic        frame_ready;
  logic [63:0] frame_seg;
  logic [7:0]  frame_en;
  logic [7:0]  blink_mask;
  logic [7:0]  seg_left;
  logic [7:0]  seg_right;
  logic [7:0]  an;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC)
`ifdef SEG_SCAN_BLINK_EN
    , .BLINK_DIV (BD)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_seg   (frame_seg),
    .frame_en    (frame_en),
`ifdef SEG_SCAN_BLINK_EN
    .blink_mask  (blink_mask),
`endif
    .seg_left    (seg_left),
    .seg_right   (seg_right),
    .an          (an)
  );

  int n_tests;
  int n_fail;

  // Reference model: k = clock edges since reset released
  int          k;
  bit          live;
  bit          m_pend;
  logic [63:0] m_sh, m_disp;
  logic [7:0]  m_sh_en, m_disp_en, m_sh_mk, m_disp_mk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (k=%0d): got %0h, expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int d;
    logic [7:0] v;
    logic [7:0] exp_an;
    d = (k / SD) % 8;
    v = m_disp_en[d] ? m_disp[8*d +: 8] : 8'h00;
`ifdef SEG_SCAN_BLINK_EN
    if (((k / BD) % 2) == 1 && m_disp_mk[d]) v = 8'h00;
`endif
    exp_an = ((k % SD) < BC) ? 8'h00 : (8'h01 << d);
    chk("an", an, exp_an);
    chk("seg_left", seg_left, (d >= 4) ? v : 8'h00);
    chk("seg_right", seg_right, (d < 4) ? v : 8'h00);
    chk("frame_ready", frame_ready, !m_pend);
  endtask

  task automatic cyc(input bit r, input bit v, input logic [63:0] s,
                     input logic [7:0] e, input logic [7:0] mk);
    bit acc;
    @(negedge clk);
    if (live) check_outputs();
    rst         = r;
    frame_valid = v;
    frame_seg   = s;
    frame_en    = e;
    blink_mask  = mk;
    acc = v && !m_pend;
    @(posedge clk);
    if (r) begin
      k = 0; m_pend = 0;
      m_sh = '0; m_disp = '0; m_sh_en = '0; m_disp_en = '0; m_sh_mk = '0; m_disp_mk = '0;
    end else begin
      k++;
      if ((k % FP) == 0 && m_pend) begin
        m_disp = m_sh; m_disp_en = m_sh_en; m_disp_mk = m_sh_mk;
        m_pend = 0;
      end
      if (acc) begin
        m_sh = s; m_sh_en = e; m_sh_mk = mk;
        m_pend = 1;
      end
    end
    live = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 4 * FP && m_pend; i++) idle(1);
    chk(tag, m_pend, 1'b0);
  endtask

  logic [63:0] fa, fb, cur_s;
  logic [7:0]  cur_e, cur_m;
  bit          got, v, a;

  initial begin
    n_tests = 0; n_fail = 0; live = 0; k = 0; m_pend = 0;
    m_sh = '0; m_disp = '0; m_sh_en = '0; m_disp_en = '0; m_sh_mk = '0; m_disp_mk = '0;
    rst = 1'b1; frame_valid = 1'b0; frame_seg = '0; frame_en = '0; blink_mask = '0;

    repeat (3) cyc(1'b1, 1'b0, '0, '0, '0);
    idle(3);

    // Directed load and full scan
    cyc(1'b0, 1'b1, 64'h0102_0408_1020_4080, 8'hFF, 8'h00);
    idle(2 * FP);

    // Back-pressure: A accepted, B held until the swap frees the shadow
    wait_ready("ready_before_A");
    fa = {$urandom, $urandom};
    fb = {$urandom, $urandom};
    cyc(1'b0, 1'b1, fa, 8'hFF, 8'h00);
    got = 0;
    for (int i = 0; i < 3 * FP && !got; i++) begin
      a = !m_pend;
      cyc(1'b0, 1'b1, fb, 8'hFF, 8'h00);
      got = a;
    end
    chk("B_accepted", got, 1'b1);
    idle(2 * FP);

    // Accept on the wrap cycle itself
    wait_ready("ready_before_wrap");
    for (int i = 0; i < 2 * FP && (k % FP) != FP - 1; i++) idle(1);
    chk("wrap_align", ((k % FP) == FP - 1) && !m_pend, 1'b1);
    cyc(1'b0, 1'b1, {$urandom, $urandom}, 8'hFF, 8'h00);
    idle(2 * FP + 2);

    // Enable mask: upper bank dark
    wait_ready("ready_before_en");
    cyc(1'b0, 1'b1, 64'hFFEE_DDCC_BBAA_9988, 8'h0F, 8'h00);
    idle(2 * FP);

    // Blink mask on digit 0 and a mix
    wait_ready("ready_before_blink");
    cyc(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'h01);
    idle(2 * FP);
    wait_ready("ready_before_blink2");
    cyc(1'b0, 1'b1, {$urandom, $urandom}, 8'hFF, 8'hA5);
    idle(2 * FP);

    // Random traffic with occasional mid-frame resets
    cur_s = {$urandom, $urandom}; cur_e = 8'($urandom); cur_m = 8'($urandom);
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        cyc(1'b1, 1'($urandom), cur_s, cur_e, cur_m);
        cyc(1'b1, 1'b0, cur_s, cur_e, cur_m);
      end else begin
        v = ($urandom_range(0, 2) == 0);
        a = v && !m_pend;
        cyc(1'b0, v, cur_s, cur_e, cur_m);
        if (a) begin
          cur_s = {$urandom, $urandom}; cur_e = 8'($urandom); cur_m = 8'($urandom);
        end
      end
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
